countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Synchronous, loadable down-counter with terminal-count detection. It is the decrementing counterpart to the design's up-counting ripple counters.
- Software or a parent FSM loads a start value. The block counts down once per enabled clock and flags expiry with a one-cycle done pulse.
- Optional auto-reload turns it into a periodic tick generator for sequencing test stimulus and display refresh.

Parameters:
- WIDTH, 3, bit width of count, load_value and the internal reload register.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture load_value into count and into the reload register.
- load_value  input  WIDTH  start or period value.
- enable  input  1  count-down qualifier; the counter decrements only on cycles where enable=1.
- auto_reload  input  1  at expiry, 1 = reload and continue, 0 = stop.
- count  output  WIDTH  current count value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at expiry.

Behaviour:
- Reset (asserted at any time, including mid-count) forces the following immediately, without waiting for clock:
  - count=0, reload register=0
  - busy=0, done=0
  - state=IDLE
- States:
  - IDLE: count holds its value; busy=0.
  - RUN: busy=1.
- Priority on each rising edge: load > expiry > decrement > hold.
- load=1, any state:
  - count <= load_value; reload register <= load_value; done <= 0.
  - If load_value != 0, next state = RUN.
  - If load_value = 0, next state = IDLE, with no done pulse.
- RUN, load=0, enable=0: count holds; done <= 0.
- RUN, load=0, enable=1, count > 1: count <= count-1; done <= 0.
- RUN, load=0, enable=1, count = 1 (expiry): done <= 1 for exactly one cycle.
  - auto_reload=1: count <= reload register; stay in RUN.
  - auto_reload=0: count <= 0; next state = IDLE.
- Period with auto_reload=1 and enable held high: done pulses every N cycles for reload value N. With N=1, done stays high continuously and count stays at 1.
- Count never wraps below 0. In IDLE, enable has no effect.
- Latency:
  - count and busy reflect a load on the first edge after load is sampled.
  - done is registered: it rises on the same edge that count leaves 1.
- Width rules:
  - Decrement is unsigned modulo 2^WIDTH, but 0 is never decremented.
  - load_value = 2^WIDTH-1 (7 for WIDTH=3) is a legal maximum period.
- auto_reload is sampled only at the expiry edge. Changing it mid-count takes effect at the next expiry.
- load asserted on the same edge as expiry: load wins, and done stays 0.

Decomposition:
- Shared package:
  - state encoding constants STATE_IDLE=0, STATE_RUN=1
  - default WIDTH constant
- Natural sub-module `down_count_slice`: a one-bit decrement slice with borrow-in/borrow-out and async reset flop, instantiated WIDTH times for the count register.
- Top level holds:
  - the reload register
  - the count==1 detect (the AND of the inverted upper bits with bit0)
  - the two-state FSM

Test Plan:
1. Reset pulse mid-RUN with count=5 -> count=0, busy=0, done=0 immediately, before the next clock edge.
2. Load 3, auto_reload=0, enable held high -> count sequence 3,2,1,0; done high only in the cycle count shows 0; busy drops to 0 on that same edge; count stays 0 afterwards.
3. Load 4, auto_reload=1, enable high for 12 cycles -> count 4,3,2,1,4,3,2,1,...; done pulses at cycles 4, 8, 12; busy stays 1 throughout.
4. Load 5, toggle enable 1,0,1,0,... -> count decrements only on enabled edges: 5,4,4,3,3,2,...
5. Load 0 -> count=0, busy=0, done never asserts.
6. Run with count=1, enable=1, and assert load=6 on the expiry edge -> count=6, done=0, busy=1.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the loadable countdown timer.
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a parent (master) and the countdown timer (slave).
// Level-qualified bus, no handshake: inputs are sampled on every rising clock edge, done is a one-cycle pulse.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  state_e           state_dbg;

  modport master (
    output load, load_value, enable, auto_reload,
    input  count, busy, done, state_dbg
  );

  modport slave (
    input  load, load_value, enable, auto_reload,
    output count, busy, done, state_dbg
  );
endinterface

// File: rtl/countdown_timer_slice.sv
// One bit of the count register: parallel set, or subtract the incoming borrow.
module down_count_slice (
  input  logic clock,
  input  logic reset,
  input  logic set_en,
  input  logic set_bit,
  input  logic dec_en,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);
  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    if (set_en) begin
      bit_d = set_bit;
    end else if (dec_en) begin
      bit_d = bit_q ^ borrow_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q          = bit_q;
  assign borrow_out = borrow_in & ~bit_q;
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse and optional periodic auto-reload.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  countdown_timer_if.slave bus
);
  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             done_q;
  logic             done_d;

  logic [WIDTH-1:0] count_w;
  logic [WIDTH:0]   borrow;
  logic             set_en;
  logic [WIDTH-1:0] set_val;
  logic             dec_en;
  logic             count_is_one;
  logic             count_is_zero;

  // A borrow rippling out of the top bit means every bit is zero.
  assign borrow[0]     = 1'b1;
  assign count_is_zero = borrow[WIDTH];
  assign count_is_one  = count_w[0] & ~(|count_w[WIDTH-1:1]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    down_count_slice u_slice (
      .clock      (clock),
      .reset      (reset),
      .set_en     (set_en),
      .set_bit    (set_val[i]),
      .dec_en     (dec_en),
      .borrow_in  (borrow[i]),
      .q          (count_w[i]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    set_en   = 1'b0;
    set_val  = '0;
    dec_en   = 1'b0;
    if (bus.load) begin
      set_en   = 1'b1;
      set_val  = bus.load_value;
      reload_d = bus.load_value;
      state_d  = (bus.load_value != '0) ? STATE_RUN : STATE_IDLE;
    end else if (state_q == STATE_RUN && bus.enable) begin
      if (count_is_one) begin
        done_d  = 1'b1;
        set_en  = 1'b1;
        set_val = bus.auto_reload ? reload_q : '0;
        state_d = bus.auto_reload ? STATE_RUN : STATE_IDLE;
      end else begin
        dec_en = ~count_is_zero;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= STATE_IDLE;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign bus.count     = count_w;
  assign bus.busy      = (state_q == STATE_RUN);
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer (WIDTH=3).
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  localparam int W = 3;

  typedef struct {
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;
    logic         auto_reload;
    logic [W-1:0] exp_count;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] c, input logic b, input logic d);
    check({tag, ".count"}, int'(bus.count), int'(c));
    check({tag, ".busy"}, int'(bus.busy), int'(b));
    check({tag, ".done"}, int'(bus.done), int'(d));
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic en, input logic ar);
    bus.load        = ld;
    bus.load_value  = lv;
    bus.enable      = en;
    bus.auto_reload = ar;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic ld, input int lv, input logic en, input logic ar,
                     input int c, input logic b, input logic d);
    vec_t v;
    v.load        = ld;
    v.load_value  = W'(lv);
    v.enable      = en;
    v.auto_reload = ar;
    v.exp_count   = W'(c);
    v.exp_busy    = b;
    v.exp_done    = d;
    vecs.push_back(v);
  endtask

  initial begin
    // one-shot 3,2,1,0 with done on the edge count leaves 1
    add(1, 3, 1, 0, 3, 1, 0);
    add(0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    // periodic reload of 4 for 12 enabled cycles
    add(1, 4, 1, 1, 4, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      add(0, 0, 1, 1, (k % 4 == 0) ? 4 : 4 - (k % 4), 1, (k % 4 == 0));
    end
    // enable toggling: only enabled edges decrement
    add(1, 5, 0, 0, 5, 1, 0);
    add(0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    // load of zero goes idle without done
    add(1, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0);
    // load on the expiry edge wins
    add(1, 2, 1, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(1, 6, 1, 0, 6, 1, 0);
    add(0, 0, 1, 0, 5, 1, 0);
    // auto_reload sampled only at expiry
    add(1, 2, 1, 1, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    // period 1: done held, count stays 1
    add(1, 1, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 1, 1);
    add(0, 0, 1, 1, 1, 1, 1);
    add(0, 0, 0, 1, 1, 1, 0);
    // maximum period value
    add(1, 7, 1, 1, 7, 1, 0);
    add(0, 0, 1, 1, 6, 1, 0);

    drive(0, '0, 0, 0);
    reset = 1'b1;
    #1;
    check_outputs("reset_init", 0, 0, 0);
    check("reset_init.state", int'(bus.state_dbg), int'(STATE_IDLE));
    step();
    reset = 1'b0;
    step();
    check_outputs("post_reset", 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].load_value, vecs[i].enable, vecs[i].auto_reload);
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // async reset mid-RUN with count=5, no clock edge needed
    drive(1, 3'd5, 0, 0);
    step();
    drive(0, '0, 0, 0);
    step();
    check_outputs("pre_async_reset", 5, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset_run", 0, 0, 0);
    #1;
    reset = 1'b0;
    step();
    check_outputs("after_async_reset", 0, 0, 0);

    // async reset while done is high clears done immediately
    drive(1, 3'd1, 1, 1);
    step();
    drive(0, '0, 1, 1);
    step();
    check_outputs("done_before_reset", 1, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset_done", 0, 0, 0);
    check("async_reset.state", int'(bus.state_dbg), int'(STATE_IDLE));
    #1;
    reset = 1'b0;
    drive(0, '0, 1, 1);
    step();
    check_outputs("idle_after_reset", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
